// File: rtl/pht_update_scheduler.sv
// PHT update scheduler: queues 2-bit counter updates from resolved branches
// and drains them onto the single PHT write port, avoiding bank conflicts
// with fetch-side reads and forcing a drain when writes starve.
module pht_update_scheduler #(
  parameter int QUEUE_SIZE   = 32,
  parameter int ENQ_WIDTH    = 2,
  parameter int RD_WIDTH     = 2,
  parameter int INDEX_WIDTH  = 10,
  parameter int BANK_BITS    = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [ENQ_WIDTH-1:0]                  enq_valid,
  input  logic [ENQ_WIDTH-1:0][INDEX_WIDTH-1:0] enq_index,
  input  logic [ENQ_WIDTH-1:0][1:0]             enq_prev_value,
  input  logic [ENQ_WIDTH-1:0]                  enq_taken,
  output logic                                  enq_ready,
  output logic                                  dropped,
  input  logic [RD_WIDTH-1:0]                   rd_valid,
  input  logic [RD_WIDTH-1:0][INDEX_WIDTH-1:0]  rd_index,
  output logic                                  fetch_stall,
  output logic                                  wr_valid,
  output logic [INDEX_WIDTH-1:0]                wr_index,
  output logic [1:0]                            wr_value,
  output logic [$clog2(QUEUE_SIZE):0]           count
);

  localparam int PTR_W = $clog2(QUEUE_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CNT_W:0] QSZ = (CNT_W+1)'(QUEUE_SIZE);
  localparam logic [CNT_W:0] EW  = (CNT_W+1)'(ENQ_WIDTH);
  localparam logic [SW-1:0]  STARVE_LAST = SW'(STARVE_LIMIT - 1);

  typedef enum logic {DRAIN = 1'b0, FORCE = 1'b1} state_t;

  // Saturating 2-bit counter step in the executed direction.
  function automatic logic [1:0] next_counter(input logic [1:0] prev, input logic taken);
    if (taken && prev != 2'd3)       return prev + 2'd1;
    else if (!taken && prev != 2'd0) return prev - 2'd1;
    else                             return prev;
  endfunction

  // Each entry holds {index, new counter value}.
  logic [INDEX_WIDTH+1:0] mem [QUEUE_SIZE];

  state_t           state, state_next;
  logic [PTR_W-1:0] head, tail;
  logic [SW-1:0]    starve, starve_next;
  logic             deq;
  logic             conflict;
  logic [INDEX_WIDTH-1:0] head_index;
  logic [1:0]             head_value;
  logic [ENQ_WIDTH-1:0]            lane_act;
  logic [ENQ_WIDTH-1:0][1:0]       lane_val;
  logic [ENQ_WIDTH-1:0][PTR_W-1:0] lane_ptr;
  logic [CNT_W-1:0] n_act, n_acc;
  logic             unused_rd_bits;

  assign unused_rd_bits = ^rd_index;
  assign {head_index, head_value} = mem[head];
  assign enq_ready   = ({1'b0, count} + EW) <= QSZ;
  assign fetch_stall = (state == FORCE);

  // Lane filtering: drop saturated no-ops and pack survivors in lane order.
  always_comb begin
    n_act    = '0;
    lane_act = '0;
    lane_val = '0;
    lane_ptr = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      lane_val[i] = next_counter(enq_prev_value[i], enq_taken[i]);
      lane_act[i] = enq_valid[i] && (lane_val[i] != enq_prev_value[i]);
      lane_ptr[i] = tail + PTR_W'(n_act);
      if (lane_act[i]) n_act = n_act + CNT_W'(1);
    end
    n_acc = enq_ready ? n_act : '0;
  end

  // Bank conflict between the head entry and any fetch read this cycle.
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < RD_WIDTH; i++)
      if (rd_valid[i] && rd_index[i][BANK_BITS-1:0] == head_index[BANK_BITS-1:0])
        conflict = 1'b1;
  end

  // Drain FSM: opportunistic drain, with a forced drain after sustained blocking.
  always_comb begin
    state_next  = state;
    starve_next = starve;
    deq         = 1'b0;
    unique case (state)
      DRAIN: begin
        if (count != '0) begin
          if (!conflict) begin
            deq         = 1'b1;
            starve_next = '0;
          end else begin
            starve_next = starve + SW'(1);
            if (starve_next == STARVE_LAST) state_next = FORCE;
          end
        end else begin
          starve_next = '0;
        end
      end
      FORCE: begin
        deq         = (count != '0);
        starve_next = '0;
        state_next  = DRAIN;
      end
      default: state_next = DRAIN;
    endcase
  end

  // Control state, pointers, occupancy and the registered write port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= DRAIN;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      starve   <= '0;
      wr_valid <= 1'b0;
      wr_index <= '0;
      wr_value <= '0;
      dropped  <= 1'b0;
    end else begin
      state    <= state_next;
      starve   <= starve_next;
      tail     <= tail + PTR_W'(n_acc);
      head     <= head + PTR_W'(deq);
      count    <= count + n_acc - CNT_W'(deq);
      wr_valid <= deq;
      dropped  <= !enq_ready && (n_act != '0);
      if (deq) begin
        wr_index <= head_index;
        wr_value <= head_value;
      end
    end
  end

  // Queue storage: accepted lanes written at consecutive slots from tail.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_WIDTH; i++)
      if (enq_ready && lane_act[i])
        mem[lane_ptr[i]] <= {enq_index[i], lane_val[i]};
  end

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Directed testbench for pht_update_scheduler with a write-order scoreboard.
module tb_pht_update_scheduler;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       enq_valid;
  logic [1:0][9:0]  enq_index;
  logic [1:0][1:0]  enq_prev_value;
  logic [1:0]       enq_taken;
  logic             enq_ready;
  logic             dropped;
  logic [1:0]       rd_valid;
  logic [1:0][9:0]  rd_index;
  logic             fetch_stall;
  logic             wr_valid;
  logic [9:0]       wr_index;
  logic [1:0]       wr_value;
  logic [5:0]       count;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q[$];

  pht_update_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .enq_valid(enq_valid), .enq_index(enq_index),
    .enq_prev_value(enq_prev_value), .enq_taken(enq_taken),
    .enq_ready(enq_ready), .dropped(dropped),
    .rd_valid(rd_valid), .rd_index(rd_index),
    .fetch_stall(fetch_stall),
    .wr_valid(wr_valid), .wr_index(wr_index), .wr_value(wr_value),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] sat_step(input logic [1:0] prev, input logic tk);
    case ({tk, prev})
      3'b100: return 2'd1;
      3'b101: return 2'd2;
      3'b110: return 2'd3;
      3'b111: return 2'd3;
      3'b000: return 2'd0;
      3'b001: return 2'd0;
      3'b010: return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int l, input logic v, input logic [9:0] idx,
                          input logic [1:0] prev, input logic tk);
    enq_valid[l]      = v;
    enq_index[l]      = idx;
    enq_prev_value[l] = prev;
    enq_taken[l]      = tk;
  endtask

  task automatic clear_lanes();
    set_lane(0, 1'b0, 10'h0, 2'd0, 1'b0);
    set_lane(1, 1'b0, 10'h0, 2'd0, 1'b0);
  endtask

  task automatic drain_all(input string tag);
    rd_valid = 2'b00;
    for (int k = 0; k < 100 && count != 6'd0; k++) step();
    check_eq(tag, count, 6'd0);
    step();
    step();
  endtask

  // Every write must match the oldest outstanding expected update.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_valid === 1'b1) begin
      check_eq("wr_expected_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_eq("wr_entry", {wr_index, wr_value}, exp_q.pop_front());
    end
  end

  initial begin
    logic [9:0] fidx;
    logic [1:0] p0, p1;
    logic       t0, t1;

    // Reset held two cycles with both lanes active.
    rst_n = 1'b0;
    rd_valid = 2'b00;
    rd_index = '0;
    set_lane(0, 1'b1, 10'h011, 2'd1, 1'b1);
    set_lane(1, 1'b1, 10'h012, 2'd2, 1'b0);
    step();
    step();
    check_eq("rst_count", count, 0);
    check_eq("rst_wr_valid", wr_valid, 0);
    check_eq("rst_enq_ready", enq_ready, 1);
    check_eq("rst_fetch_stall", fetch_stall, 0);
    check_eq("rst_dropped", dropped, 0);
    clear_lanes();
    rst_n = 1'b1;
    step();
    check_eq("rel_count", count, 0);
    check_eq("rel_wr_valid", wr_valid, 0);
    check_eq("rel_enq_ready", enq_ready, 1);
    check_eq("rel_fetch_stall", fetch_stall, 0);

    // Lane 1 saturated (prev 3 taken) is filtered; lane 0 goes 1 -> 2.
    set_lane(0, 1'b1, 10'h005, 2'd1, 1'b1);
    set_lane(1, 1'b1, 10'h010, 2'd3, 1'b1);
    exp_q.push_back({10'h005, 2'd2});
    step();
    clear_lanes();
    check_eq("t2_count1", count, 1);
    check_eq("t2_no_bypass", wr_valid, 0);
    step();
    check_eq("t2_wr_valid", wr_valid, 1);
    check_eq("t2_wr_index", wr_index, 10'h005);
    check_eq("t2_wr_value", wr_value, 2'd2);
    check_eq("t2_count0", count, 0);
    step();
    check_eq("t2_wr_idle", wr_valid, 0);

    // Starvation: read on bank 0 every cycle blocks head 0x004.
    rd_valid = 2'b01;
    rd_index[0] = 10'h002;
    set_lane(0, 1'b1, 10'h004, 2'd1, 1'b1);
    exp_q.push_back({10'h004, 2'd2});
    step();
    clear_lanes();
    check_eq("t3_count", count, 1);
    for (int k = 1; k <= 6; k++) begin
      step();
      check_eq("t3_blocked_wr", wr_valid, 0);
      check_eq("t3_blocked_stall", fetch_stall, 0);
    end
    step();
    check_eq("t3_stall", fetch_stall, 1);
    check_eq("t3_stall_wr", wr_valid, 0);
    step();
    check_eq("t3_forced_wr", wr_valid, 1);
    check_eq("t3_forced_idx", wr_index, 10'h004);
    check_eq("t3_stall_off", fetch_stall, 0);
    check_eq("t3_count0", count, 0);

    // Reads on bank 1 never block bank-0 heads: one write per cycle.
    rd_index[0] = 10'h003;
    for (int c = 0; c < 8; c++) begin
      if (c < 3) begin
        set_lane(0, 1'b1, 10'(10'h004 + 4 * c), 2'd0, 1'b1);
        set_lane(1, 1'b1, 10'(10'h006 + 4 * c), 2'd0, 1'b1);
        exp_q.push_back({10'(10'h004 + 4 * c), 2'd1});
        exp_q.push_back({10'(10'h006 + 4 * c), 2'd1});
      end else begin
        clear_lanes();
      end
      step();
      check_eq("t4_wr_valid", wr_valid, (c >= 1 && c <= 6) ? 1 : 0);
      check_eq("t4_no_stall", fetch_stall, 0);
    end
    check_eq("t4_count0", count, 0);

    // Fill to 31 under bank-0 conflict, then an overflowing 2-lane enqueue.
    rd_index[0] = 10'h002;
    fidx = 10'h040;
    for (int e = 1; e <= 19; e++) begin
      clear_lanes();
      if (e <= 18) begin
        set_lane(0, 1'b1, fidx, 2'd2, 1'b0);
        if (e != 16) set_lane(1, 1'b1, 10'(fidx + 2), 2'd2, 1'b0);
        if (e <= 17) begin
          exp_q.push_back({fidx, 2'd1});
          if (e != 16) exp_q.push_back({10'(fidx + 2), 2'd1});
        end
        fidx = 10'(fidx + 4);
      end
      step();
      if (e == 8)  begin check_eq("t5_stall_a", fetch_stall, 1); check_eq("t5_count16", count, 16); end
      if (e == 16) begin check_eq("t5_stall_b", fetch_stall, 1); check_eq("t5_count30", count, 30); end
      if (e == 17) begin
        check_eq("t5_count31", count, 31);
        check_eq("t5_not_ready", enq_ready, 0);
        check_eq("t5_no_drop_yet", dropped, 0);
      end
      if (e == 18) begin
        check_eq("t5_dropped", dropped, 1);
        check_eq("t5_count_kept", count, 31);
        check_eq("t5_still_not_ready", enq_ready, 0);
      end
      if (e == 19) begin
        check_eq("t5_drop_pulse", dropped, 0);
        check_eq("t5_count_hold", count, 31);
      end
    end
    drain_all("t5_drain_timeout");
    check_eq("t5_ready_again", enq_ready, 1);

    // Forty updates across pointer wrap, enqueue cycles interleaved with idle ones.
    for (int i = 0; i < 20; i++) begin
      p0 = 2'(i % 4);       t0 = 1'(i % 2);
      p1 = 2'((i * 3) % 4); t1 = 1'((i / 2) % 2 == 0);
      set_lane(0, 1'b1, 10'(10'h100 + i), p0, t0);
      set_lane(1, 1'b1, 10'(10'h200 + i), p1, t1);
      if (sat_step(p0, t0) != p0) exp_q.push_back({10'(10'h100 + i), sat_step(p0, t0)});
      if (sat_step(p1, t1) != p1) exp_q.push_back({10'(10'h200 + i), sat_step(p1, t1)});
      rd_valid = 2'b01;
      rd_index[0] = 10'(i);
      step();
      clear_lanes();
      rd_valid = 2'b00;
      step();
      check_eq("t6_no_drop", dropped, 0);
    end
    drain_all("t6_drain_timeout");
    check_eq("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
